// File: rtl/button_debounce_pkg.sv
// -----------------------------------------------------------------------------
// button_debounce_pkg
// Shared constants for the push-button debouncer: default parameter values
// and the FSM state encodings used by the core and exposed for debug.
// -----------------------------------------------------------------------------
package button_debounce_pkg;

    // Defaults sized for a 100 MHz clock.
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms
    localparam int DEF_REPEAT_EN       = 1;
    localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 10000000;  // 100 ms

    // Repeat FSM state encodings.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE       = 2'd0;  // debounced level is 0
    localparam state_t ST_HOLD_DELAY = 2'd1;  // pressed, waiting for first repeat
    localparam state_t ST_REPEATING  = 2'd2;  // pressed, emitting periodic repeats

endpackage : button_debounce_pkg

// File: rtl/button_debounce_if.sv
// -----------------------------------------------------------------------------
// button_debounce_if
// Bundles the button input and the debounced outputs of button_debounce.
//   btn_i     : raw asynchronous button level (driven by master)
//   level_o   : debounced level
//   press_o   : one-cycle pulse on each debounced rise
//   release_o : one-cycle pulse on each debounced fall
//   count_o   : one-cycle count-enable pulse (press plus auto-repeats)
//   state_o   : repeat FSM state, for observation only
// Protocol: there is no valid/ready handshake here. level_o is a level; the
// three pulse outputs are each high for exactly one clk cycle per event and
// the consumer must sample them on every rising clk edge.
// -----------------------------------------------------------------------------
interface button_debounce_if;
    import button_debounce_pkg::*;

    logic   btn_i;
    logic   level_o;
    logic   press_o;
    logic   release_o;
    logic   count_o;
    state_t state_o;

    // Master: drives the button, observes the results.
    modport master (
        output btn_i,
        input  level_o, press_o, release_o, count_o, state_o
    );

    // Slave: the debouncer itself.
    modport slave (
        input  btn_i,
        output level_o, press_o, release_o, count_o, state_o
    );

endinterface : button_debounce_if

// File: rtl/sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (second flop)
// -----------------------------------------------------------------------------
module sync_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule : sync_bit

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronizes and debounces a bouncing push-button, produces press/release
// pulses and a count-enable pulse that auto-repeats while the button is held.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : button_debounce_if.slave (btn_i in; level_o, press_o, release_o,
//           count_o, state_o out)
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable samples needed to change level (>=1)
//   REPEAT_EN       : 1 enables auto-repeat of count_o while held
//   REPEAT_DELAY    : clocks from press to first repeat pulse (>=1)
//   REPEAT_PERIOD   : clocks between later repeat pulses (>=1)
// -----------------------------------------------------------------------------
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = DEF_REPEAT_EN,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              rst_n,
    button_debounce_if.slave  bus
);

    // Parameter range checks at elaboration.
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_delay
        $error("button_debounce: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_bad_period
        $error("button_debounce: REPEAT_PERIOD must be >= 1");
    end

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    // One timer serves both the initial delay and the repeat period.
    localparam int RT_W  = (($clog2(REPEAT_DELAY) > $clog2(REPEAT_PERIOD)) ?
                            $clog2(REPEAT_DELAY) : $clog2(REPEAT_PERIOD)) + 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RT_W-1:0] RD_FULL = RT_W'(REPEAT_DELAY);
    localparam logic [RT_W-1:0] RD_LAST = RT_W'(REPEAT_DELAY - 1);
    localparam logic [RT_W-1:0] RP_LAST = RT_W'(REPEAT_PERIOD - 1);

    // ---------------------------------------------------------------- sync
    logic s_btn;

    sync_bit u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_i),
        .q     (s_btn)
    );

    // ------------------------------------------------------------ debounce
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            toggle_c;
    logic            rise_c;
    logic            fall_c;

    // Count consecutive samples that disagree with the current level; any
    // agreeing sample restarts the count.
    always_comb begin
        db_cnt_d = '0;
        toggle_c = 1'b0;
        if (s_btn != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                toggle_c = 1'b1;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign level_d = level_q ^ toggle_c;
    assign rise_c  = toggle_c & ~level_q;
    assign fall_c  = toggle_c &  level_q;

    // ---------------------------------------------------------- repeat FSM
    state_t          state_q, state_d;
    logic [RT_W-1:0] tmr_q, tmr_d;
    logic            rep_c;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rep_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_c) begin
                    state_d = ST_HOLD_DELAY;
                    tmr_d   = '0;
                end
            end
            ST_HOLD_DELAY: begin
                if (fall_c) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else if ((REPEAT_EN != 0) && (tmr_q == RD_LAST)) begin
                    rep_c   = 1'b1;
                    state_d = ST_REPEATING;
                    tmr_d   = '0;
                end else if (tmr_q != RD_FULL) begin
                    // Saturates at REPEAT_DELAY when repeat is disabled.
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_REPEATING: begin
                if (fall_c) begin
                    // A repeat due on the release edge is dropped.
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else if (tmr_q == RP_LAST) begin
                    rep_c = 1'b1;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------ registers
    logic press_q;
    logic release_q;
    logic count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            press_q   <= rise_c;
            release_q <= fall_c;
            count_q   <= rise_c | rep_c;
        end
    end

    assign bus.level_o   = level_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.count_o   = count_q;
    assign bus.state_o   = state_q;

endmodule : button_debounce

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Two instances share clock, reset and button stimulus:
// dut_en (REPEAT_EN=1) and dut_dis (REPEAT_EN=0).
// Outputs are sampled 1 time unit after each rising edge. Output vectors are
// packed as {level, press, release, count}.
// -----------------------------------------------------------------------------
module tb_button_debounce;
    import button_debounce_pkg::*;

    // ---------------------------------------------------- clock and reset
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    button_debounce_if bus_en ();
    button_debounce_if bus_dis ();

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut_en (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_en.slave)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut_dis (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_dis.slave)
    );

    // ------------------------------------------------------------ scoreboard
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // --------------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic v);
        bus_en.btn_i  = v;
        bus_dis.btn_i = v;
    endtask

    function automatic logic [3:0] outs_en();
        return {bus_en.level_o, bus_en.press_o, bus_en.release_o, bus_en.count_o};
    endfunction

    function automatic logic [3:0] outs_dis();
        return {bus_dis.level_o, bus_dis.press_o, bus_dis.release_o, bus_dis.count_o};
    endfunction

    // Expected count_o of the repeating instance k edges after the press edge.
    function automatic logic rep_exp(input int k);
        return (k == 10) || (k > 10 && ((k - 10) % 3) == 0);
    endfunction

    // Watchdog: the test is a fixed-length directed sequence.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- stimulus
    int pulses_en;
    int pulses_dis;

    initial begin
        rst_n = 1'b0;
        set_btn(1'b0);
        #3;
        check("reset_outs_en",  outs_en(),  4'b0000);
        check("reset_outs_dis", outs_dis(), 4'b0000);
        check("reset_state_en", bus_en.state_o, ST_IDLE);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("first_cycle_after_reset", outs_en(), 4'b0000);
        repeat (3) step();

        // Clean press, auto-repeat, release suppressing a due repeat.
        set_btn(1'b1);
        for (int e = 1; e <= 5; e++) begin
            step();
            check($sformatf("press_wait_e%0d", e), outs_en(), 4'b0000);
        end
        step();  // edge 6 = P
        check("press_edge_en",  outs_en(),  4'b1101);
        check("press_edge_dis", outs_dis(), 4'b1101);
        check("press_state",    bus_en.state_o, ST_HOLD_DELAY);
        for (int k = 1; k <= 25; k++) begin
            step();
            check($sformatf("hold_P+%0d", k), outs_en(), {3'b100, rep_exp(k)});
            if (k == 11) check("state_repeating", bus_en.state_o, ST_REPEATING);
        end
        set_btn(1'b0);
        for (int k = 26; k <= 30; k++) begin
            step();
            check($sformatf("rel_wait_P+%0d", k), outs_en(), {3'b100, rep_exp(k)});
        end
        step();  // P+31: release edge, repeat would be due here
        check("release_edge",  outs_en(), 4'b0010);
        check("release_state", bus_en.state_o, ST_IDLE);
        for (int k = 32; k <= 35; k++) begin
            step();
            check($sformatf("after_release_P+%0d", k), outs_en(), 4'b0000);
        end

        // Bounce: 1 for 3 edges, 0 for 1, then 1 held.
        repeat (4) step();
        set_btn(1'b1);
        for (int e = 1; e <= 9; e++) begin
            if (e == 4) set_btn(1'b0);
            if (e == 5) set_btn(1'b1);
            step();
            check($sformatf("bounce_e%0d", e), outs_en(), 4'b0000);
        end
        step();  // edge 10
        check("bounce_rise", outs_en(), 4'b1101);
        set_btn(1'b0);
        repeat (10) step();
        check("bounce_released",     outs_en(),  4'b0000);
        check("bounce_released_dis", outs_dis(), 4'b0000);

        // Repeat disabled: hold 50 cycles after press.
        pulses_en  = 0;
        pulses_dis = 0;
        set_btn(1'b1);
        for (int e = 1; e <= 56; e++) begin
            step();
            if (bus_en.count_o)  pulses_en++;
            if (bus_dis.count_o) pulses_dis++;
        end
        check("norepeat_pulses",  pulses_dis, 1);
        check("repeat_pulses",    pulses_en, 15);
        check("norepeat_state",   bus_dis.state_o, ST_HOLD_DELAY);
        check("norepeat_level",   bus_dis.level_o, 1'b1);
        check("repeating_state",  bus_en.state_o, ST_REPEATING);

        // Reset mid-repeat with the button held.
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outs_en",  outs_en(),  4'b0000);
        check("midreset_outs_dis", outs_dis(), 4'b0000);
        check("midreset_state",    bus_en.state_o, ST_IDLE);
        step();
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            check($sformatf("repress_wait_e%0d", e), outs_en(), 4'b0000);
        end
        step();
        check("repress_edge_en",  outs_en(),  4'b1101);
        check("repress_edge_dis", outs_dis(), 4'b1101);
        step();
        check("repress_after", outs_en(), 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_button_debounce

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the number of consecutive stable synchronized samples required to change state (10 ms at 100 MHz); legal range >= 1.
REQ-002 Parameter REPEAT_EN, default 1, SHALL enable auto-repeat of count_o while held (1) or disable it (0).
REQ-003 Parameter REPEAT_DELAY, default 50000000, SHALL set the clocks from press to the first repeat pulse; legal range >= 1.
REQ-004 Parameter REPEAT_PERIOD, default 10000000, SHALL set the clocks between subsequent repeat pulses; legal range >= 1.
REQ-005 clk  input  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 btn_i  input  1  raw, asynchronous, bouncing push-button level, active-high.
REQ-008 level_o  output  1  debounced button level.
REQ-009 press_o  output  1  one-cycle pulse on each debounced 0->1 transition.
REQ-010 release_o  output  1  one-cycle pulse on each debounced 1->0 transition.
REQ-011 count_o  output  1  one-cycle count-enable pulse for the downstream counter's count input (press plus repeats).

Function
REQ-012 btn_i SHALL pass through a two-flop synchronizer; the second-flop output (s_btn) is the only value used downstream.
REQ-013 A stability counter SHALL increment on each edge where s_btn != level_o and SHALL clear to 0 on any edge where s_btn == level_o.
REQ-014 On the edge where s_btn != level_o and the counter equals DEBOUNCE_CYCLES-1, level_o SHALL toggle and the counter SHALL clear; a steady btn_i change therefore reaches level_o on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge sampling the new value.
REQ-015 Any single-cycle reversion of s_btn before that point SHALL restart the count from 0; no output SHALL change.
REQ-016 press_o and count_o SHALL be 1 in exactly the cycle following the edge where level_o rises (registered, aligned with the new level_o); release_o likewise on the fall.
REQ-017 FSM states: IDLE (level_o=0), HOLD_DELAY, REPEATING.
REQ-018 IDLE->HOLD_DELAY on level_o rise; repeat timer loads 0.
REQ-019 HOLD_DELAY: timer increments each cycle; when it reaches REPEAT_DELAY (edge P+REPEAT_DELAY, P = press edge), count_o SHALL pulse and state SHALL go to REPEATING with timer cleared, only if REPEAT_EN=1; with REPEAT_EN=0 state SHALL remain HOLD_DELAY and the timer SHALL saturate.
REQ-020 REPEATING: count_o SHALL pulse every REPEAT_PERIOD cycles, i.e. at P+REPEAT_DELAY+k*REPEAT_PERIOD, k>=1.
REQ-021 From HOLD_DELAY or REPEATING, a level_o fall SHALL return to IDLE on the same edge, clear the timer and suppress any repeat pulse due on that edge; count_o SHALL never pulse on release.
REQ-022 Counter widths SHALL be $clog2 of the respective parameter + 1 bit; no counter SHALL wrap.

Reset
REQ-023 rst_n low SHALL immediately force level_o, press_o, release_o, count_o to 0, both synchronizer flops to 0, all counters to 0 and the FSM to IDLE.
REQ-024 Reset asserted mid-press or mid-repeat SHALL discard all history; after deassertion a held button SHALL be re-debounced from zero and produce a fresh press_o.
REQ-025 No output SHALL pulse in the first cycle after rst_n deassertion.

Structure
REQ-026 Shared package button_debounce_pkg SHALL hold FSM state encodings and default parameter constants.
REQ-027 The two-flop synchronizer SHALL be a separate sub-module named sync_bit (clk, rst_n, d, q).
REQ-028 Parameter range violations SHALL be caught by elaboration-time checks.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless stated)
REQ-029 Clean press: btn_i 0->1 sampled at edge 1, held -> level_o=1 after edge 6; press_o and count_o high exactly one cycle, after edge 6.
REQ-030 Bounce: btn_i 1 for 3 edges, 0 for 1, then 1 held -> no output change until 4 consecutive stable s_btn samples; level_o rises 6 edges after the final 0->1.
REQ-031 Auto-repeat: hold 30 cycles after press P -> count_o pulses at P, P+10, P+13, P+16 ... P+28; press_o only at P.
REQ-032 Release: btn_i 1->0 held -> level_o falls 6 edges later, release_o one-cycle pulse, no count_o, repeat stops.
REQ-033 REPEAT_EN=0: hold 50 cycles -> exactly one count_o pulse.
REQ-034 Reset mid-repeat: rst_n low for 2 cycles with btn_i held -> all outputs 0 immediately; after release, fresh press_o/count_o 6 edges later.
